// File: rtl/cpu_pkg.sv
//==============================================================================
// Package  : cpu_pkg
// Desc     : Shared core widths, register/word types and the x0 constant.
// Revision : 1.0
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_addr_t X0 = '0;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/wb_scoreboard.sv
//==============================================================================
// Module   : wb_scoreboard
// Desc     : Busy bits for registers awaiting a long-latency writeback.
// Revision : 1.0
//==============================================================================
`default_nettype none

module wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int AW = cpu_pkg::AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    input  logic              clr_valid,
    input  logic [AW-1:0]     clr_addr,
    output logic [2**AW-1:0]  busy
);

    localparam int c_NREG = 2**AW;

    logic [c_NREG-1:0] r_busy;
    logic [c_NREG-1:0] w_busy_nxt;
    logic              w_issue_fire;

    assign issue_ready  = !rst && ((issue_rd == AW'(X0)) || !r_busy[issue_rd]);
    assign w_issue_fire = issue_valid && issue_ready && (issue_rd != AW'(X0));
    assign busy         = r_busy;

    // A set on the same index as a clear takes precedence.
    for (genvar i = 0; i < c_NREG; i++) begin : g_bit
        if (i == 0) begin : g_x0
            assign w_busy_nxt[i] = 1'b0;
        end else begin : g_reg
            assign w_busy_nxt[i] = (w_issue_fire && (issue_rd == AW'(i))) ||
                                   (r_busy[i] && !(clr_valid && (clr_addr == AW'(i))));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

endmodule : wb_scoreboard

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
//==============================================================================
// Module   : regfile_wb_arbiter
// Desc     : Arbitrates two writeback sources onto the single RF write port.
// Revision : 1.0
//==============================================================================
`default_nettype none

module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int XLEN         = cpu_pkg::XLEN,
    parameter int AW           = cpu_pkg::AW,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [AW-1:0]     req0_addr,
    input  logic [XLEN-1:0]   req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [AW-1:0]     req1_addr,
    input  logic [XLEN-1:0]   req1_data,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    output logic [2**AW-1:0]  busy,
    output logic              rf_we,
    output logic [AW-1:0]     rf_wa,
    output logic [XLEN-1:0]   rf_wd
);

    localparam int             c_SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_LIMIT = c_SW'(STARVE_LIMIT);

    logic [c_SW-1:0] r_starve;
    logic            w_grant0;
    logic            w_grant1;
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_write;

    // req1 only wins a contested cycle once it has lost STARVE_LIMIT in a row.
    assign w_grant1 = !rst && req1_valid && (!req0_valid || (r_starve == c_LIMIT));
    assign w_grant0 = !rst && req0_valid && !w_grant1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_addr  = w_grant1 ? req1_addr : req0_addr;
    assign w_data  = w_grant1 ? req1_data : req0_data;
    assign w_write = (w_grant0 || w_grant1) && (w_addr != AW'(X0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_grant1) begin
            r_starve <= '0;
        end else if (req1_valid && (r_starve != c_LIMIT)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // x0 writes are accepted to drain the requester but never reach the RF.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (w_write) begin
            rf_we <= 1'b1;
            rf_wa <= w_addr;
            rf_wd <= w_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    wb_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .clr_valid   (w_grant1),
        .clr_addr    (req1_addr),
        .busy        (busy)
    );

endmodule : regfile_wb_arbiter

`default_nettype wire
